// File: rtl/fc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_pkg                                                                     |
// | Shared types and helpers for the FC layer datapath blocks.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fc_pkg;

  typedef enum logic [2:0] {
    s_ld_idle  = 3'd0,
    s_ld_fill  = 3'd1,
    s_ld_zero  = 3'd2,
    s_ld_wait  = 3'd3,
    s_ld_start = 3'd4
  } t_ld_state;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fc_rd_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_rd_addr_gen                                                             |
// | Tile/row write-address counter for the RD input buffers.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fc_rd_addr_gen
  import fc_pkg::*;
#(
  parameter int INPUT_SIZE   = 512,
  parameter int XBAR_SIZE    = 256,
  localparam int V_CIM_TILES = ceil_div(INPUT_SIZE, XBAR_SIZE),
  localparam int ROW_W       = $clog2(XBAR_SIZE),
  localparam int TILE_W      = (V_CIM_TILES > 1) ? $clog2(V_CIM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [TILE_W-1:0] tile,
  output logic [ROW_W-1:0]  row,
  output logic              last_word,
  output logic              last_row
);

  localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(XBAR_SIZE - 1);
  localparam logic [ROW_W-1:0]  LAST_WORD_ROW = ROW_W'((INPUT_SIZE - 1) % XBAR_SIZE);
  localparam logic [TILE_W-1:0] LAST_TILE     = TILE_W'(V_CIM_TILES - 1);

  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ROW_W-1:0]  row_q, row_d;

  always_comb begin
    tile_d = tile_q;
    row_d  = row_q;
    if (clr) begin
      tile_d = '0;
      row_d  = '0;
    end else if (inc) begin
      if (row_q == LAST_ROW) begin
        row_d = '0;
        // Tile index saturates so a trailing increment never leaves the array.
        if (tile_q != LAST_TILE) begin
          tile_d = tile_q + TILE_W'(1);
        end
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      row_q  <= '0;
    end else begin
      tile_q <= tile_d;
      row_q  <= row_d;
    end
  end

  assign tile      = tile_q;
  assign row       = row_q;
  assign last_word = (tile_q == LAST_TILE) && (row_q == LAST_WORD_ROW);
  assign last_row  = (row_q == LAST_ROW);

endmodule
`default_nettype wire

// File: rtl/fc_rd_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_rd_loader                                                               |
// | Scatters an activation stream into the RD buffers, zero-fills, starts CIM. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fc_rd_loader
  import fc_pkg::*;
#(
  parameter int INPUT_SIZE    = 512,
  parameter int XBAR_SIZE     = 256,
  parameter int DATATYPE_SIZE = 8,
  localparam int V_CIM_TILES  = ceil_div(INPUT_SIZE, XBAR_SIZE),
  localparam int ROW_W        = $clog2(XBAR_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [DATATYPE_SIZE-1:0] i_data,
  output logic                     o_ready,
  output logic                     o_busy,
  input  logic                     i_cim_busy,
  output logic                     o_cim_start,
  output logic [V_CIM_TILES-1:0]   o_rd_we,
  output logic [ROW_W-1:0]         o_rd_addr,
  output logic [DATATYPE_SIZE-1:0] o_rd_data
);

  localparam int TILE_W = (V_CIM_TILES > 1) ? $clog2(V_CIM_TILES) : 1;
  localparam t_ld_state FILL_EXIT = ((INPUT_SIZE % XBAR_SIZE) != 0) ? s_ld_zero : s_ld_wait;

  t_ld_state                state_q, state_d;
  logic                     hold_q;
  logic                     start_q, start_d;
  logic [V_CIM_TILES-1:0]   we_q, we_d;
  logic [ROW_W-1:0]         addr_q, addr_d;
  logic [DATATYPE_SIZE-1:0] data_q, data_d;

  logic [TILE_W-1:0] tile;
  logic [ROW_W-1:0]  row;
  logic              last_word, last_row;
  logic              cnt_clr, cnt_inc;
  logic              ready, busy, accept;

  fc_rd_addr_gen #(
    .INPUT_SIZE (INPUT_SIZE),
    .XBAR_SIZE  (XBAR_SIZE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .tile      (tile),
    .row       (row),
    .last_word (last_word),
    .last_row  (last_row)
  );

  always_comb begin
    state_d = state_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    ready   = 1'b0;
    busy    = 1'b1;

    // hold_q keeps the reset-state handshake outputs for the cycle rst is high.
    case (state_q)
      s_ld_idle: begin
        ready = !hold_q && !i_cim_busy;
        busy  = hold_q || i_cim_busy;
      end
      s_ld_fill: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      default: ;
    endcase
    accept = i_valid && ready;

    case (state_q)
      s_ld_idle, s_ld_fill: begin
        if (accept) begin
          we_d[tile] = 1'b1;
          addr_d     = row;
          data_d     = i_data;
          cnt_inc    = 1'b1;
          state_d    = last_word ? FILL_EXIT : s_ld_fill;
        end
      end
      s_ld_zero: begin
        we_d[tile] = 1'b1;
        addr_d     = row;
        data_d     = '0;
        cnt_inc    = 1'b1;
        if (last_row) begin
          state_d = s_ld_wait;
        end
      end
      s_ld_wait: begin
        if (!i_cim_busy) begin
          state_d = s_ld_start;
        end
      end
      s_ld_start: begin
        if (i_cim_busy) begin
          cnt_clr = 1'b1;
          state_d = s_ld_idle;
        end
      end
      default: state_d = s_ld_idle;
    endcase

    start_d = (state_d == s_ld_start);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= s_ld_idle;
      hold_q  <= 1'b1;
      start_q <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
      start_q <= start_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_ready     = ready;
  assign o_busy      = busy;
  assign o_cim_start = start_q;
  assign o_rd_we     = we_q;
  assign o_rd_addr   = addr_q;
  assign o_rd_data   = data_q;

  // CIM must not start computing while the RD buffers are still being written.
  a_no_busy_rise_in_load: assert property (
    @(posedge clk) disable iff (rst)
    ((state_q == s_ld_fill) || (state_q == s_ld_zero)) |-> !$rose(i_cim_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_fc_rd_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fc_rd_loader                                                            |
// | Directed bench: 512-word (no zero fill) and 257-word (zero fill) layers.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fc_rd_loader;

  typedef struct {
    int         tile;
    int         row;
    logic [7:0] exp;
  } mem_vec_t;

  typedef struct {
    logic busy;
    logic exp_ready;
    logic exp_obusy;
  } idle_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_valid, a_busy, a_ready, a_obusy, a_start;
  logic [7:0] a_data, a_addr, a_rdata;
  logic [1:0] a_we;
  logic       b_valid, b_busy, b_ready, b_obusy, b_start;
  logic [7:0] b_data, b_addr, b_rdata;
  logic [1:0] b_we;

  int checks = 0;
  int errors = 0;

  fc_rd_loader dut_a (
    .clk(clk), .rst(rst), .i_valid(a_valid), .i_data(a_data), .o_ready(a_ready),
    .o_busy(a_obusy), .i_cim_busy(a_busy), .o_cim_start(a_start), .o_rd_we(a_we),
    .o_rd_addr(a_addr), .o_rd_data(a_rdata)
  );

  fc_rd_loader #(.INPUT_SIZE(257)) dut_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .i_data(b_data), .o_ready(b_ready),
    .o_busy(b_obusy), .i_cim_busy(b_busy), .o_cim_start(b_start), .o_rd_we(b_we),
    .o_rd_addr(b_addr), .o_rd_data(b_rdata)
  );

  // Shadow copies of the RD buffers rebuilt from the write port.
  logic [7:0] mem_a [2][256];
  logic [7:0] mem_b [2][256];
  int wr_a = 0, wr_b = 0, oh_a = 0, oh_b = 0, zc_b = 0;

  always @(posedge clk) begin
    if (a_we != 2'b00) begin
      wr_a <= wr_a + 1;
      if (a_we == 2'b01) mem_a[0][a_addr] <= a_rdata;
      else if (a_we == 2'b10) mem_a[1][a_addr] <= a_rdata;
      else oh_a <= oh_a + 1;
    end
    if (b_we != 2'b00) begin
      wr_b <= wr_b + 1;
      if (b_we == 2'b01) mem_b[0][b_addr] <= b_rdata;
      else if (b_we == 2'b10) begin
        mem_b[1][b_addr] <= b_rdata;
        if (b_addr != 8'd0 && b_rdata == 8'd0) zc_b <= zc_b + 1;
      end
      else oh_b <= oh_b + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    int n;
    a_valid = 1'b1;
    a_data  = d;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_a_timeout", 1, 0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    int n;
    b_valid = 1'b1;
    b_data  = d;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_b_timeout", 1, 0);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic scan_a(input int pat, output int bad);
    logic [7:0] e;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      case (pat)
        0:       e = 8'(k + 1);
        1:       e = 8'(k * 3 + 7);
        default: e = 8'(k) ^ 8'h5A;
      endcase
      if (mem_a[k / 256][k % 256] !== e) bad++;
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ready"}, a_ready, 0);
    chk({tag, "_busy"},  a_obusy, 1);
    chk({tag, "_start"}, a_start, 0);
    chk({tag, "_we"},    a_we, 0);
    chk({tag, "_addr"},  a_addr, 0);
    chk({tag, "_data"},  a_rdata, 0);
  endtask

  mem_vec_t  mv [6];
  idle_vec_t iv [3];

  initial begin
    int bad, base, n, gap_bad, sbad, rbad;

    mv[0] = '{0, 0,   8'h01};
    mv[1] = '{0, 127, 8'h80};
    mv[2] = '{0, 255, 8'h00};
    mv[3] = '{1, 0,   8'h01};
    mv[4] = '{1, 200, 8'hC9};
    mv[5] = '{1, 255, 8'h00};
    iv[0] = '{1'b0, 1'b1, 1'b0};
    iv[1] = '{1'b1, 1'b0, 1'b1};
    iv[2] = '{1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    a_valid = 1'b0; a_busy = 1'b0; a_data = '0;
    b_valid = 1'b0; b_busy = 1'b0; b_data = '0;
    tick();
    tick();
    chk_reset_a("rst0");
    chk("rst0_b_busy", b_obusy, 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      a_busy = iv[i].busy;
      #1;
      chk("idle_ready", a_ready, iv[i].exp_ready);
      chk("idle_busy", a_obusy, iv[i].exp_obusy);
    end

    // Full 512-word layer, back to back.
    for (int k = 0; k < 512; k++) push_a(8'(k + 1));
    chk("t1_start_early", a_start, 0);
    chk("t1_ready_after_last", a_ready, 0);
    tick();
    chk("t1_start", a_start, 1);
    chk("t1_busy_in_start", a_obusy, 1);
    for (int i = 0; i < 6; i++) chk("t1_mem", mem_a[mv[i].tile][mv[i].row], mv[i].exp);
    scan_a(0, bad);
    chk("t1_scan", bad, 0);
    chk("t1_writes", wr_a, 512);
    a_busy = 1'b1;
    tick();
    chk("t1_ack_start", a_start, 0);
    chk("t1_ack_busy", a_obusy, 1);
    chk("t1_ack_ready", a_ready, 0);
    a_busy = 1'b0;
    #1;
    chk("t1_idle_busy", a_obusy, 0);
    chk("t1_idle_ready", a_ready, 1);

    // Gapped fill, then CIM still busy when the buffers complete.
    base = wr_a;
    gap_bad = 0;
    for (int k = 0; k < 512; k++) begin
      push_a(8'(k * 3 + 7));
      if (k != 511) begin
        tick();
        if (a_we != 2'b00) gap_bad++;
      end
    end
    a_busy = 1'b1;
    sbad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_start) sbad++;
    end
    chk("t4_no_start_while_busy", sbad, 0);
    chk("t4_wait_ready", a_ready, 0);
    chk("t3_gap_writes", gap_bad, 0);
    chk("t3_writes", wr_a - base, 512);
    scan_a(1, bad);
    chk("t3_scan", bad, 0);
    a_busy = 1'b0;
    tick();
    chk("t4_start", a_start, 1);
    tick();
    tick();
    chk("t4_start_held", a_start, 1);
    a_busy = 1'b1;
    tick();
    chk("t4_ack_start", a_start, 0);
    chk("t4_ack_busy", a_obusy, 1);
    a_busy = 1'b0;
    #1;
    chk("t4_idle_ready", a_ready, 1);

    // 257-word layer: one word in tile 1, then 255 zero rows; valid held high meanwhile.
    for (int k = 0; k < 257; k++) push_b(8'(160 + k));
    b_valid = 1'b1;
    b_data  = 8'h55;
    n = 0;
    rbad = 0;
    while (!b_start && n < 400) begin
      if (b_ready) rbad++;
      tick();
      n++;
    end
    chk("t2_latency", n, 256);
    chk("t6_ready_low", rbad, 0);
    chk("t2_writes", wr_b, 512);
    chk("t2_zero_writes", zc_b, 255);
    chk("t2_t0r0", mem_b[0][0], 8'hA0);
    chk("t2_t0r255", mem_b[0][255], 8'h9F);
    chk("t2_t1r0", mem_b[1][0], 8'hA0);
    bad = 0;
    for (int r = 1; r < 256; r++) if (mem_b[1][r] !== 8'h00) bad++;
    chk("t2_zero_rows", bad, 0);
    b_valid = 1'b0;
    b_busy = 1'b1;
    tick();
    chk("t2_ack_start", b_start, 0);
    b_busy = 1'b0;

    // Reset in mid-fill, then a complete layer from row 0.
    for (int k = 0; k < 100; k++) push_a(8'(k));
    rst = 1'b1;
    tick();
    chk_reset_a("t5_rst");
    rst = 1'b0;
    tick();
    chk("t5_idle_ready", a_ready, 1);
    base = wr_a;
    for (int k = 0; k < 512; k++) push_a(8'(k) ^ 8'h5A);
    tick();
    tick();
    chk("t5_start", a_start, 1);
    chk("t5_writes", wr_a - base, 512);
    scan_a(2, bad);
    chk("t5_scan", bad, 0);
    a_busy = 1'b1;
    tick();
    a_busy = 1'b0;

    chk("onehot_a", oh_a, 0);
    chk("onehot_b", oh_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
